// File: rtl/cc_line_serializer.sv
// Line-FIFO consumer: pops one cache line and replays it as DATA_WIDTH beats on a valid/ready channel.
// Optional macro CC_SER_WRAP_EN enables critical-word-first (wrap-order) beat issue from the head's start_ofs field.
module cc_line_serializer #(
    parameter int LINE_WIDTH = 512,
    parameter int DATA_WIDTH = 64,
    localparam int BEATS     = LINE_WIDTH / DATA_WIDTH,
    localparam int BEAT_LG2  = $clog2(BEATS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fifo_empty_i,
    input  logic [LINE_WIDTH+BEAT_LG2-1:0] fifo_rdata_i,
    output logic                           fifo_rden_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           rlast_o,
    output logic [BEAT_LG2-1:0]            rbeat_o,
    output logic                           busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [BEAT_LG2-1:0] LAST_CNT = BEAT_LG2'(BEATS - 1);
    localparam logic [BEAT_LG2-1:0] CNT_ONE  = BEAT_LG2'(1);

    state_t                               state_q, state_d;
    logic [BEATS-1:0][DATA_WIDTH-1:0]     line_q;
    logic [BEAT_LG2-1:0]                  start_q, start_d;
    logic [BEAT_LG2-1:0]                  cnt_q;
    logic [BEAT_LG2-1:0]                  beat;
    logic                                 last_beat;
    logic                                 handshake;
    logic                                 pop;

`ifdef CC_SER_WRAP_EN
    assign start_d = fifo_rdata_i[LINE_WIDTH +: BEAT_LG2];
`else
    // Offset field is carried by the FIFO but deliberately ignored in this build.
    logic unused_ofs;
    assign unused_ofs = ^fifo_rdata_i[LINE_WIDTH +: BEAT_LG2];
    assign start_d    = '0;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        pop         = 1'b0;
        beat        = start_q + cnt_q;
        last_beat   = (cnt_q == LAST_CNT);
        handshake   = (state_q == SEND) && rready_i;
        rvalid_o    = (state_q == SEND);
        busy_o      = (state_q == SEND);
        rlast_o     = (state_q == SEND) && last_beat;
        rbeat_o     = beat;
        rdata_o     = line_q[beat];

        unique case (state_q)
            IDLE: begin
                pop = ~fifo_empty_i;
                if (pop) state_d = SEND;
            end
            SEND: begin
                // Refill on the final handshake so consecutive lines stream without a bubble.
                if (handshake && last_beat) begin
                    pop     = ~fifo_empty_i;
                    state_d = pop ? SEND : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) pop = 1'b0;
        fifo_rden_o = pop;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            // NOTE: the line register is reset (it is a flop bank, not a RAM) so rdata_o reads zero out of reset.
            line_q  <= '0;
            start_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                line_q  <= fifo_rdata_i[LINE_WIDTH-1:0];
                start_q <= start_d;
                cnt_q   <= '0;
            end else if (handshake) begin
                cnt_q   <= cnt_q + CNT_ONE;
            end
        end
    end

endmodule
